// File: rtl/hw_dispatch_pkg.sv
// Shared constants and types for the hardware dispatch peripheral front end.
package hw_dispatch_pkg;

  // Word-aligned byte offsets decoded on each core's demux port
  localparam int unsigned DISP_OFF_FIFO = 'h0;
  localparam int unsigned DISP_OFF_CONF = 'h4;

  // reg_sel encodings understood by the dispatcher
  localparam logic [1:0] DISP_SEL_PUSH = 2'd0;
  localparam logic [1:0] DISP_SEL_CONF = 2'd1;

  typedef enum logic [1:0] {
    StIdle,
    StWaitEvt,
    StResp
  } disp_state_e;

endpackage

// File: rtl/hw_dispatch_periph_ch.sv
// Single-core channel: decodes one port's accesses and sequences pops against the dispatcher.
module hw_dispatch_periph_ch
  import hw_dispatch_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] add_i,
  input  logic              wen_i,
  input  logic [31:0]       wdata_i,
  output logic              gnt_o,
  output logic              r_valid_o,
  output logic [31:0]       r_rdata_o,
  output logic              r_opc_o,
  output logic              core_waiting_o,
  output logic              pop_req_o,
  output logic              pop_ack_o,
  input  logic [31:0]       dispatch_value_i,
  input  logic              dispatch_event_i,
  output logic              w_req_o,
  output logic [31:0]       w_data_o,
  output logic [1:0]        reg_sel_o
);

  disp_state_e state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        opc_q, opc_d;

  logic is_fifo, is_conf;
  assign is_fifo = (add_i == ADDR_W'(DISP_OFF_FIFO));
  assign is_conf = (add_i == ADDR_W'(DISP_OFF_CONF));

  // Response data/opcode are only non-zero while in StResp.
  assign r_rdata_o = rdata_q;
  assign r_opc_o   = opc_q;

  // Next-state and strobe decode; strobes are forced low while reset is asserted.
  always_comb begin
    state_d        = state_q;
    rdata_d        = rdata_q;
    opc_d          = opc_q;
    gnt_o          = 1'b0;
    r_valid_o      = 1'b0;
    core_waiting_o = 1'b0;
    pop_req_o      = 1'b0;
    pop_ack_o      = 1'b0;
    w_req_o        = 1'b0;
    w_data_o       = '0;
    reg_sel_o      = DISP_SEL_PUSH;
    if (rst_ni) begin
      unique case (state_q)
        StIdle: begin
          gnt_o = req_i;
          if (req_i) begin
            if (wen_i && is_fifo) begin
              pop_req_o = 1'b1;
              state_d   = StWaitEvt;
            end else if (!wen_i && (is_fifo || is_conf)) begin
              w_req_o   = 1'b1;
              w_data_o  = wdata_i;
              reg_sel_o = is_conf ? DISP_SEL_CONF : DISP_SEL_PUSH;
              rdata_d   = '0;
              opc_d     = 1'b0;
              state_d   = StResp;
            end else begin
              rdata_d = '0;
              opc_d   = 1'b1;
              state_d = StResp;
            end
          end
        end
        StWaitEvt: begin
          core_waiting_o = 1'b1;
          if (dispatch_event_i) begin
            pop_ack_o = 1'b1;
            rdata_d   = dispatch_value_i;
            opc_d     = 1'b0;
            state_d   = StResp;
          end
        end
        StResp: begin
          // Grant is held off here so a new pop_req lands >= 2 cycles after pop_ack.
          r_valid_o = 1'b1;
          rdata_d   = '0;
          opc_d     = 1'b0;
          state_d   = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rdata_q <= '0;
      opc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      opc_q   <= opc_d;
    end
  end

endmodule

// File: rtl/hw_dispatch_periph_if.sv
// Per-core peripheral front end for the hardware dispatch FIFO: one channel FSM per core.
module hw_dispatch_periph_if
  import hw_dispatch_pkg::*;
#(
  parameter int unsigned NB_CORES = 4,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NB_CORES-1:0]              req_i,
  input  logic [NB_CORES-1:0][ADDR_W-1:0]  add_i,
  input  logic [NB_CORES-1:0]              wen_i,
  input  logic [NB_CORES-1:0][31:0]        wdata_i,
  output logic [NB_CORES-1:0]              gnt_o,
  output logic [NB_CORES-1:0]              r_valid_o,
  output logic [NB_CORES-1:0][31:0]        r_rdata_o,
  output logic [NB_CORES-1:0]              r_opc_o,
  output logic [NB_CORES-1:0]              core_waiting_o,
  output logic [NB_CORES-1:0]              pop_req_o,
  output logic [NB_CORES-1:0]              pop_ack_o,
  input  logic [NB_CORES-1:0][31:0]        dispatch_value_i,
  input  logic [NB_CORES-1:0]              dispatch_event_i,
  output logic [NB_CORES-1:0]              w_req_o,
  output logic [NB_CORES-1:0][31:0]        w_data_o,
  output logic [NB_CORES-1:0][1:0]         reg_sel_o
);

  for (genvar i = 0; i < NB_CORES; i++) begin : g_ch
    hw_dispatch_periph_ch #(
      .ADDR_W(ADDR_W)
    ) u_ch (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .req_i           (req_i[i]),
      .add_i           (add_i[i]),
      .wen_i           (wen_i[i]),
      .wdata_i         (wdata_i[i]),
      .gnt_o           (gnt_o[i]),
      .r_valid_o       (r_valid_o[i]),
      .r_rdata_o       (r_rdata_o[i]),
      .r_opc_o         (r_opc_o[i]),
      .core_waiting_o  (core_waiting_o[i]),
      .pop_req_o       (pop_req_o[i]),
      .pop_ack_o       (pop_ack_o[i]),
      .dispatch_value_i(dispatch_value_i[i]),
      .dispatch_event_i(dispatch_event_i[i]),
      .w_req_o         (w_req_o[i]),
      .w_data_o        (w_data_o[i]),
      .reg_sel_o       (reg_sel_o[i])
    );
  end

endmodule

// File: tb/tb_hw_dispatch_periph_if.sv
// Bench for hw_dispatch_periph_if: directed stimulus, response scoreboard checked by a monitor.
module tb_hw_dispatch_periph_if;

  localparam int NC = 4;
  localparam int AW = 4;

  logic                    clk = 1'b0;
  logic                    rst_ni = 1'b0;
  logic [NC-1:0]           req, wen, devt;
  logic [NC-1:0][AW-1:0]   add;
  logic [NC-1:0][31:0]     wdata, dval;
  logic [NC-1:0]           gnt, r_valid, r_opc, waiting, pop_req, pop_ack, w_req;
  logic [NC-1:0][31:0]     r_rdata, w_data;
  logic [NC-1:0][1:0]      reg_sel;

  hw_dispatch_periph_if #(
    .NB_CORES(NC),
    .ADDR_W  (AW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_i           (req),
    .add_i           (add),
    .wen_i           (wen),
    .wdata_i         (wdata),
    .gnt_o           (gnt),
    .r_valid_o       (r_valid),
    .r_rdata_o       (r_rdata),
    .r_opc_o         (r_opc),
    .core_waiting_o  (waiting),
    .pop_req_o       (pop_req),
    .pop_ack_o       (pop_ack),
    .dispatch_value_i(dval),
    .dispatch_event_i(devt),
    .w_req_o         (w_req),
    .w_data_o        (w_data),
    .reg_sel_o       (reg_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        opc;
    int          due;
  } exp_t;

  exp_t sbq [NC][$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response expected on the cycle after the current one.
  task automatic expect_rsp(input int c, input logic [31:0] d, input logic o);
    exp_t e;
    e.rdata = d;
    e.opc   = o;
    e.due   = cyc + 1;
    sbq[c].push_back(e);
  endtask

  // Monitor: every response pulse must match the head of its core's queue.
  always @(negedge clk) begin
    if (rst_ni) begin
      for (int i = 0; i < NC; i++) begin
        if (r_valid[i]) begin
          exp_t e;
          if (sbq[i].size() == 0) begin
            chk($sformatf("unexpected_r_valid_core%0d", i), 64'd1, 64'd0);
          end else begin
            e = sbq[i].pop_front();
            chk($sformatf("rsp_rdata_core%0d", i), r_rdata[i], e.rdata);
            chk($sformatf("rsp_opc_core%0d", i), r_opc[i], e.opc);
            chk($sformatf("rsp_cycle_core%0d", i), cyc, e.due);
          end
        end
      end
    end
  end

  task automatic wr(input int c, input logic [3:0] a, input logic [31:0] d, input logic [1:0] sel);
    @(posedge clk); #1;
    req[c] = 1'b1; add[c] = a; wen[c] = 1'b0; wdata[c] = d;
    @(negedge clk);
    chk("wr_gnt", gnt[c], 1);
    chk("wr_w_req", w_req, 64'(1) << c);
    chk("wr_reg_sel", reg_sel[c], sel);
    chk("wr_w_data", w_data[c], d);
    expect_rsp(c, 32'h0, 1'b0);
    @(posedge clk); #1;
    req[c] = 1'b0; wdata[c] = '0;
    @(negedge clk);
    chk("wr_w_req_after", w_req, 0);
    chk("wr_w_data_after", |w_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req = '0; wen = '0; devt = '0; add = '0; wdata = '0; dval = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl_outs", {gnt, r_valid, r_opc, waiting, pop_req, pop_ack, w_req}, 0);
    chk("reset_rdata", |r_rdata, 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // 1: core0 team-config write then push write
    wr(0, 4'h4, 32'h3, 2'd1);
    wr(0, 4'h0, 32'hCAFE, 2'd0);

    // 2: core1 pop with the event 5 cycles after pop_req
    @(posedge clk); #1;
    req[1] = 1'b1; add[1] = 4'h0; wen[1] = 1'b1;
    @(negedge clk);
    chk("pop1_gnt", gnt[1], 1);
    chk("pop1_pop_req", pop_req, 4'b0010);
    @(posedge clk); #1;
    req[1] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("pop1_waiting", waiting[1], 1);
      chk("pop1_no_ack", pop_ack[1], 0);
      @(posedge clk); #1;
    end
    devt[1] = 1'b1; dval[1] = 32'hCAFE;
    @(negedge clk);
    chk("pop1_waiting_evt", waiting[1], 1);
    chk("pop1_ack", pop_ack, 4'b0010);
    expect_rsp(1, 32'hCAFE, 1'b0);
    @(posedge clk); #1;
    devt[1] = 1'b0; dval[1] = '0;
    @(negedge clk);
    chk("pop1_waiting_resp", waiting[1], 0);

    // 3: core2 back-to-back pops with req held
    @(posedge clk); #1;
    req[2] = 1'b1; add[2] = 4'h0; wen[2] = 1'b1;
    @(negedge clk);
    chk("b2b_gnt0", gnt[2], 1);
    chk("b2b_pop_req0", pop_req[2], 1);
    @(posedge clk); #1;
    devt[2] = 1'b1; dval[2] = 32'h11;
    @(negedge clk);
    chk("b2b_gnt_wait", gnt[2], 0);
    chk("b2b_ack0", pop_ack[2], 1);
    chk("b2b_no_req_at_ack", pop_req[2], 0);
    expect_rsp(2, 32'h11, 1'b0);
    @(posedge clk); #1;
    devt[2] = 1'b0;
    @(negedge clk);
    chk("b2b_gnt_resp", gnt[2], 0);
    chk("b2b_no_req_after_ack", pop_req[2], 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_gnt1", gnt[2], 1);
    chk("b2b_pop_req1", pop_req[2], 1);
    @(posedge clk); #1;
    req[2] = 1'b0; devt[2] = 1'b1; dval[2] = 32'h22;
    @(negedge clk);
    chk("b2b_ack1", pop_ack[2], 1);
    expect_rsp(2, 32'h22, 1'b0);
    @(posedge clk); #1;
    devt[2] = 1'b0; dval[2] = '0;
    repeat (2) @(posedge clk);

    // 4: decode errors on core3 (read 0x8) and core0 (read 0x4)
    #1;
    req[3] = 1'b1; add[3] = 4'h8; wen[3] = 1'b1;
    req[0] = 1'b1; add[0] = 4'h4; wen[0] = 1'b1;
    @(negedge clk);
    chk("err_gnt", gnt, 4'b1001);
    chk("err_no_w_req", w_req, 0);
    chk("err_no_pop_req", pop_req, 0);
    expect_rsp(3, 32'h0, 1'b1);
    expect_rsp(0, 32'h0, 1'b1);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk("err_no_strobes", {w_req, pop_req, pop_ack}, 0);
    repeat (2) @(posedge clk);

    // 5: async reset while cores 0 and 1 wait for events
    #1;
    req[0] = 1'b1; add[0] = 4'h0; wen[0] = 1'b1;
    req[1] = 1'b1; add[1] = 4'h0; wen[1] = 1'b1;
    @(negedge clk);
    chk("rst_pop_req", pop_req, 4'b0011);
    @(posedge clk); #1;
    req = '0;
    @(posedge clk); #1;
    chk("rst_waiting_before", waiting, 4'b0011);
    #2;
    rst_ni = 1'b0; devt[0] = 1'b1; dval[0] = 32'h77; req[2] = 1'b1;
    #1;
    chk("rst_ctrl_outs", {gnt, r_valid, r_opc, waiting, pop_req, pop_ack, w_req}, 0);
    chk("rst_w_data", |w_data, 0);
    chk("rst_reg_sel", reg_sel, 0);
    chk("rst_rdata", |r_rdata, 0);
    @(posedge clk);
    @(negedge clk); #2;
    rst_ni = 1'b1; devt = '0; dval = '0; req = '0;
    @(posedge clk); #1;
    req[0] = 1'b1; add[0] = 4'h0; wen[0] = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", gnt[0], 1);
    chk("post_rst_pop_req", pop_req, 4'b0001);
    @(posedge clk); #1;
    req[0] = 1'b0; devt[0] = 1'b1; dval[0] = 32'h55;
    @(negedge clk);
    chk("post_rst_ack", pop_ack[0], 1);
    expect_rsp(0, 32'h55, 1'b0);
    @(posedge clk); #1;
    devt[0] = 1'b0; dval[0] = '0;

    // 6: event on an idle core is ignored
    repeat (2) @(posedge clk);
    #1;
    devt[3] = 1'b1; dval[3] = 32'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_evt_no_ack", pop_ack[3], 0);
      chk("idle_evt_no_wait", waiting[3], 0);
      @(posedge clk); #1;
    end
    devt[3] = 1'b0; dval[3] = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("scoreboard_drained_core%0d", i), sbq[i].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hw_dispatch_periph_if.md
Name: hw_dispatch_periph_if

Overview:
Per-core peripheral-bus front end for the hardware dispatch FIFO.
- Decodes each core's demux-port accesses into push, team-config and pop operations.
- Drives the dispatcher's pop_req/pop_ack/w_req/w_data/reg_sel inputs.
- Stalls a popping core until the dispatcher raises its event, then returns the dispatched value on the response channel.
- Sits directly upstream of the dispatcher inside the event unit.

Parameters:
NB_CORES, 4, number of cores/ports; one independent channel FSM per core.
ADDR_W, 4, width of the byte-offset address decoded per port.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_i  in  NB_CORES  per-core bus request
add_i  in  NB_CORES x ADDR_W  per-core byte offset
wen_i  in  NB_CORES  1 = read, 0 = write
wdata_i  in  NB_CORES x 32  write data
gnt_o  out  NB_CORES  grant, combinational, same cycle as req
r_valid_o  out  NB_CORES  response valid, one-cycle pulse
r_rdata_o  out  NB_CORES x 32  response data
r_opc_o  out  NB_CORES  1 = decode error
core_waiting_o  out  NB_CORES  core stalled on a pop, used by the clock-gating logic
pop_req_o  out  NB_CORES  to dispatcher: start pop
pop_ack_o  out  NB_CORES  to dispatcher: value consumed
dispatch_value_i  in  NB_CORES x 32  from dispatcher
dispatch_event_i  in  NB_CORES  from dispatcher: value valid for core
w_req_o  out  NB_CORES  to dispatcher: write strobe
w_data_o  out  NB_CORES x 32  to dispatcher
reg_sel_o  out  NB_CORES x 2  to dispatcher: 0 = push value, 1 = team config

Behaviour:
Address map (offset, word aligned):
- 0x0: read = pop, write = push.
- 0x4: write = team config; read = decode error, rdata 0.
- Any other offset: decode error, rdata 0.

Per-core FSM states: IDLE, WAIT_EVT, RESP. Reset state is IDLE. Reset values: every output 0 and r_rdata 0.

IDLE:
- req_i is granted the same cycle; gnt_o = req_i.
- Pop read: pop_req_o pulses 1 cycle; next state WAIT_EVT.
- Write to 0x0 or 0x4: w_req_o = 1 the same cycle, w_data_o = wdata_i, reg_sel_o = add[2]. Next state RESP with r_opc = 0.
- Error access: next state RESP with r_opc = 1, rdata 0.
- The dispatcher latches the pop request, so pop_req_o is never held high.

WAIT_EVT:
- gnt_o = 0. core_waiting_o = 1.
- On dispatch_event_i: capture dispatch_value_i into the r_rdata register and pulse pop_ack_o in the same cycle. Next state RESP.
- There is no timeout; the wait is unbounded.

RESP:
- r_valid_o = 1 for exactly one cycle with the registered rdata/opc. gnt_o = 0. Then IDLE.

Latency:
- Write or error access: response 1 cycle after grant.
- Pop: response 1 cycle after the event. The earliest event is the cycle after pop_req, so the minimum pop latency is 2 cycles.

Back-to-back pops:
- The dispatcher advances its read pointer 2 cycles after pop_ack. Blocking grants in RESP guarantees the next pop_req is ≥2 cycles after pop_ack, which is required for correctness.
- The implementation must never issue pop_req in the cycle directly after pop_ack.

Other rules:
- w_data_o is 0 whenever w_req_o is 0, because the dispatcher OR-reduces data across cores.
- Cores are independent. Simultaneous writes from several cores are passed through unchanged; arbitration is the dispatcher's concern.
- An event arriving while the channel is not in WAIT_EVT is ignored.
- Asynchronous reset mid-operation: FSM returns to IDLE, no response is issued, and pop_ack/pop_req are deasserted immediately.

Decomposition:
- Package hw_dispatch_pkg holds:
  - the offsets (DISP_OFF_FIFO = 'h0, DISP_OFF_CONF = 'h4);
  - the reg_sel encodings (DISP_SEL_PUSH = 0, DISP_SEL_CONF = 1);
  - the FSM state enum.
- One sub-module, hw_dispatch_periph_ch, is the single-core FSM, instantiated NB_CORES times by a generate loop.

Test Plan:
1. Core0 writes 0x4 = 0x3, then 0x0 = 0xCAFE → w_req_o[0] pulses with reg_sel 1 then 0, w_data matching. r_valid one cycle after each grant, opc 0.
2. Core1 pops, dispatch_event_i[1] raised 5 cycles later with value 0xCAFE → core_waiting_o[1] high for those 5 cycles. pop_ack_o[1] coincides with the event. r_valid and rdata 0xCAFE one cycle later.
3. Core2 issues back-to-back pop reads with req held → grant low in RESP. The second pop_req_o comes exactly 2 cycles after pop_ack_o.
4. Core3 reads 0x8, and core0 reads 0x4 → gnt same cycle, r_valid next cycle with opc 1 and rdata 0. No dispatcher strobes.
5. Cores 0 and 1 in WAIT_EVT, rst_ni pulsed low asynchronously → all outputs 0 immediately. IDLE after release, and a new pop accepted in the first cycle.
6. dispatch_event_i asserted on an idle core → no pop_ack, no r_valid.
